// File: rtl/r4booth_pipe.sv
// Radix-4 Booth multiplier in a 3-stage pipeline with valid/ready handshake.
// Signed/unsigned mode and a sideband tag travel with each transaction.
module r4booth_pipe #(
  parameter int unsigned N     = 13,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_signed
);

  localparam int unsigned P = 2 * N;
  localparam int unsigned E = (N % 2 == 0) ? N + 2 : N + 1;
  localparam int unsigned G = E / 2;
  localparam int unsigned H = (G + 1) / 2;

  logic stall;

  logic [P-1:0]     a_ext;
  logic [E:0]       b_rec;
  logic [P-1:0]     pp_mag;
  logic [P-1:0]     pp_d [G];
  logic [P-1:0]     pp_q [G];
  logic             s1_valid_d, s1_valid_q;
  logic             s1_signed_d, s1_signed_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

  logic [P-1:0]     pp_pad [2*H];
  logic [P-1:0]     sum_d [H];
  logic [P-1:0]     sum_q [H];
  logic             s2_valid_d, s2_valid_q;
  logic             s2_signed_d, s2_signed_q;
  logic [TAG_W-1:0] s2_tag_d, s2_tag_q;

  logic [P-1:0]     product_d, product_q;
  logic             out_valid_d, out_valid_q;
  logic             out_signed_d, out_signed_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  // A single global stall freezes every stage while the output is blocked.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1: Booth recoding; B carries an implicit zero below bit 0.
  always_comb begin
    a_ext       = {{N{in_signed & multiplicand[N-1]}}, multiplicand};
    b_rec       = {{(E-N){in_signed & multiplier[N-1]}}, multiplier, 1'b0};
    pp_mag      = '0;
    s1_valid_d  = in_valid;
    s1_signed_d = in_signed;
    s1_tag_d    = in_tag;
    for (int i = 0; i < G; i++) begin
      case (b_rec[2*i +: 3])
        3'b001, 3'b010: pp_mag = a_ext;
        3'b011:         pp_mag = a_ext << 1;
        3'b100:         pp_mag = -(a_ext << 1);
        3'b101, 3'b110: pp_mag = -a_ext;
        default:        pp_mag = '0;
      endcase
      pp_d[i] = pp_mag << (2 * i);
    end
  end

  // Stage 2: pairwise sums; a zero pad makes an odd leftover pass through.
  always_comb begin
    pp_pad      = '{default: '0};
    s2_valid_d  = s1_valid_q;
    s2_signed_d = s1_signed_q;
    s2_tag_d    = s1_tag_q;
    for (int k = 0; k < G; k++) pp_pad[k] = pp_q[k];
    for (int j = 0; j < H; j++) sum_d[j] = pp_pad[2*j] + pp_pad[2*j+1];
  end

  // Stage 3: final reduction, modulo 2^(2N).
  always_comb begin
    product_d    = '0;
    out_valid_d  = s2_valid_q;
    out_signed_d = s2_signed_q;
    out_tag_d    = s2_tag_q;
    for (int j = 0; j < H; j++) product_d = product_d + sum_q[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_signed_q  <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_signed_q  <= 1'b0;
      s2_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_signed_q <= 1'b0;
      out_tag_q    <= '0;
      product_q    <= '0;
      for (int i = 0; i < G; i++) pp_q[i] <= '0;
      for (int j = 0; j < H; j++) sum_q[j] <= '0;
    end else if (!stall) begin
      s1_valid_q   <= s1_valid_d;
      s1_signed_q  <= s1_signed_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_signed_q  <= s2_signed_d;
      s2_tag_q     <= s2_tag_d;
      out_valid_q  <= out_valid_d;
      out_signed_q <= out_signed_d;
      out_tag_q    <= out_tag_d;
      product_q    <= product_d;
      for (int i = 0; i < G; i++) pp_q[i] <= pp_d[i];
      for (int j = 0; j < H; j++) sum_q[j] <= sum_d[j];
    end
  end

  assign out_valid  = out_valid_q;
  assign product    = product_q;
  assign out_tag    = out_tag_q;
  assign out_signed = out_signed_q;

endmodule

// File: tb/tb_r4booth_pipe.sv
// Directed and random checks of r4booth_pipe at N = 4, 8, 13, 16 and 32.
module tb_r4booth_pipe;

  localparam int unsigned TW = 4;

  logic          clk, rst, in_valid, in_signed, out_ready;
  logic [31:0]   a32, b32;
  logic [TW-1:0] in_tag;

  logic ir4, ov4, os4;     logic [7:0]  p4;  logic [TW-1:0] ot4;
  logic ir8, ov8, os8;     logic [15:0] p8;  logic [TW-1:0] ot8;
  logic ir13, ov13, os13;  logic [25:0] p13; logic [TW-1:0] ot13;
  logic ir16, ov16, os16;  logic [31:0] p16; logic [TW-1:0] ot16;
  logic ir32, ov32, os32;  logic [63:0] p32; logic [TW-1:0] ot32;

  int total;
  int bad;

  r4booth_pipe #(.N(4), .TAG_W(TW)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_signed(in_signed),
    .multiplicand(a32[3:0]), .multiplier(b32[3:0]), .in_tag(in_tag),
    .out_valid(ov4), .out_ready(out_ready), .product(p4), .out_tag(ot4), .out_signed(os4));

  r4booth_pipe #(.N(8), .TAG_W(TW)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_signed(in_signed),
    .multiplicand(a32[7:0]), .multiplier(b32[7:0]), .in_tag(in_tag),
    .out_valid(ov8), .out_ready(out_ready), .product(p8), .out_tag(ot8), .out_signed(os8));

  r4booth_pipe #(.N(13), .TAG_W(TW)) u13 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir13), .in_signed(in_signed),
    .multiplicand(a32[12:0]), .multiplier(b32[12:0]), .in_tag(in_tag),
    .out_valid(ov13), .out_ready(out_ready), .product(p13), .out_tag(ot13), .out_signed(os13));

  r4booth_pipe #(.N(16), .TAG_W(TW)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .in_signed(in_signed),
    .multiplicand(a32[15:0]), .multiplier(b32[15:0]), .in_tag(in_tag),
    .out_valid(ov16), .out_ready(out_ready), .product(p16), .out_tag(ot16), .out_signed(os16));

  r4booth_pipe #(.N(32), .TAG_W(TW)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .in_signed(in_signed),
    .multiplicand(a32), .multiplier(b32), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .product(p32), .out_tag(ot32), .out_signed(os32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend both operands to 64 bits, multiply, keep the low 2n bits.
  function automatic logic [63:0] ref_mul(input int unsigned n, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] m, ae, be, pm;
    m  = (64'd1 << n) - 64'd1;
    ae = {32'd0, a} & m;
    be = {32'd0, b} & m;
    if (s && ae[n-1]) ae = ae | ~m;
    if (s && be[n-1]) be = be | ~m;
    pm = (n >= 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
    return (ae * be) & pm;
  endfunction

  function automatic logic [31:0] stream_a(input int i);
    return 32'(i * 911 + 37);
  endfunction

  function automatic logic [31:0] stream_b(input int i);
    return 32'(8191 - i * 805);
  endfunction

  task automatic drive(input logic v, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] t);
    in_valid  = v;
    in_signed = s;
    a32       = a;
    b32       = b;
    in_tag    = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({ov13, p13, ot13, os13} !== 31'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {ov13, p13, ot13, os13});
    end
    total++;
    if (ir13 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir13); end
    drive(1'b1, 1'b0, 32'd5, 32'd7, 4'd9);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({ov13, ir13} !== 2'b01) begin
      bad++; $display("FAIL reset_held got=%b exp=01", {ov13, ir13});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b1;
  endtask

  task automatic test_unsigned_max();
    drive(1'b1, 1'b0, 32'd8191, 32'd8191, 4'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    total++;
    if (ov13 !== 1'b0) begin bad++; $display("FAIL umax_lat1 got=%b exp=0", ov13); end
    @(negedge clk);
    total++;
    if (ov13 !== 1'b0) begin bad++; $display("FAIL umax_lat2 got=%b exp=0", ov13); end
    @(negedge clk);
    total++;
    if ({ov13, p13, ot13, os13} !== {1'b1, 26'd67092481, 4'd5, 1'b0}) begin
      bad++; $display("FAIL umax_result got=%b/%0d/%0d/%b exp=1/67092481/5/0", ov13, p13, ot13, os13);
    end
    @(negedge clk);
    total++;
    if (ov13 !== 1'b0) begin bad++; $display("FAIL umax_single got=%b exp=0", ov13); end
  endtask

  task automatic test_signed_min13();
    drive(1'b1, 1'b1, 32'h1000, 32'd4095, 4'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h1000, 32'h1000, 4'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    total++;
    if ({ov13, p13, ot13, os13} !== {1'b1, 26'h3001000, 4'd1, 1'b1}) begin
      bad++; $display("FAIL smin_neg got=%b/%h/%0d/%b exp=1/3001000/1/1", ov13, p13, ot13, os13);
    end
    @(negedge clk);
    total++;
    if ({ov13, p13, ot13, os13} !== {1'b1, 26'h1000000, 4'd2, 1'b1}) begin
      bad++; $display("FAIL smin_sq got=%b/%h/%0d/%b exp=1/1000000/2/1", ov13, p13, ot13, os13);
    end
    @(negedge clk);
  endtask

  task automatic test_mixed_n8();
    drive(1'b1, 1'b1, 32'h80, 32'h80, 4'd3);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFF, 32'hFF, 4'd4);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    total++;
    if ({ov8, p8, ot8, os8} !== {1'b1, 16'h4000, 4'd3, 1'b1}) begin
      bad++; $display("FAIL n8_signed got=%b/%h/%0d/%b exp=1/4000/3/1", ov8, p8, ot8, os8);
    end
    @(negedge clk);
    total++;
    if ({ov8, p8, ot8, os8} !== {1'b1, 16'hFE01, 4'd4, 1'b0}) begin
      bad++; $display("FAIL n8_unsigned got=%b/%h/%0d/%b exp=1/fe01/4/0", ov8, p8, ot8, os8);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [31:0]   pat;
    logic          stall_exp, hold;
    logic [25:0]   held_p;
    logic [TW-1:0] held_t;
    logic [63:0]   e;
    int tx, rx, cyc;
    pat = 32'b1011_0010_1110_0011_0101_1001_0011_0110;
    tx = 0; rx = 0; cyc = 0; hold = 1'b0;
    held_p = '0; held_t = '0;
    while (rx < 10 && cyc < 300) begin
      out_ready = pat[cyc % 32];
      if (tx < 10 && pat[(cyc + 7) % 32])
        drive(1'b1, tx[0], stream_a(tx), stream_b(tx), TW'(tx));
      else
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      #1;
      stall_exp = ov13 && !out_ready;
      total++;
      if (ir13 !== !stall_exp) begin
        bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=%b", cyc, ir13, !stall_exp);
      end
      if (hold) begin
        total++;
        if ({p13, ot13} !== {held_p, held_t}) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%h/%0d exp=%h/%0d", cyc, p13, ot13, held_p, held_t);
        end
      end
      if (ov13) begin
        e = ref_mul(13, stream_a(rx), stream_b(rx), rx[0]);
        total++;
        if ({p13, ot13, os13} !== {e[25:0], TW'(rx), rx[0]}) begin
          bad++; $display("FAIL stall_result got=%h/%0d/%b exp=%h/%0d/%b", p13, ot13, os13, e[25:0], rx, rx[0]);
        end
        if (out_ready) rx++;
      end
      hold   = stall_exp;
      held_p = p13;
      held_t = ot13;
      if (in_valid && !stall_exp) tx++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rx != 10) begin bad++; $display("FAIL stall_budget got=%0d exp=10", rx); end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'd100, 32'd200, 4'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd300, 32'd400, 4'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    total++;
    if (ov13 !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", ov13); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({ov13, p13, ot13, os13} !== 31'd0) begin
      bad++; $display("FAIL rstmid_clear got=%h exp=0", {ov13, p13, ot13, os13});
    end
    total++;
    if (ir13 !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ir13); end
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (ov13 !== 1'b0) begin bad++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", i, ov13); end
    end
    drive(1'b1, 1'b1, 32'd3, 32'h1FFB, 4'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ov13, p13, ot13, os13} !== {1'b1, 26'h3FFFFF1, 4'd7, 1'b1}) begin
      bad++; $display("FAIL rstmid_next got=%b/%h/%0d/%b exp=1/3fffff1/7/1", ov13, p13, ot13, os13);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0]   qa[$];
    logic [31:0]   qb[$];
    logic          qs[$];
    logic [TW-1:0] qt[$];
    logic [31:0]   corner [5];
    logic [31:0]   a, b;
    logic          s, v;
    logic [TW-1:0] t;
    logic [63:0]   e;
    corner = '{32'h8, 32'h80, 32'h1000, 32'h8000, 32'h80000000};
    out_ready = 1'b1;
    for (int i = 0; i < 10720; i++) begin
      if (ov13) begin
        if (qa.size() == 0) begin
          total++; bad++; $display("FAIL rand_extra cyc=%0d got=valid exp=idle", i);
        end else begin
          a = qa.pop_front(); b = qb.pop_front(); s = qs.pop_front(); t = qt.pop_front();
          e = ref_mul(4, a, b, s);
          total++;
          if ({ov4, os4, ot4, ir4, p4} !== {1'b1, s, t, 1'b1, e[7:0]}) begin
            bad++; $display("FAIL rand_n4 a=%h b=%h s=%b got=%h exp=%h", a, b, s, p4, e[7:0]);
          end
          e = ref_mul(8, a, b, s);
          total++;
          if ({ov8, os8, ot8, ir8, p8} !== {1'b1, s, t, 1'b1, e[15:0]}) begin
            bad++; $display("FAIL rand_n8 a=%h b=%h s=%b got=%h exp=%h", a, b, s, p8, e[15:0]);
          end
          e = ref_mul(13, a, b, s);
          total++;
          if ({ov13, os13, ot13, ir13, p13} !== {1'b1, s, t, 1'b1, e[25:0]}) begin
            bad++; $display("FAIL rand_n13 a=%h b=%h s=%b got=%h exp=%h", a, b, s, p13, e[25:0]);
          end
          e = ref_mul(16, a, b, s);
          total++;
          if ({ov16, os16, ot16, ir16, p16} !== {1'b1, s, t, 1'b1, e[31:0]}) begin
            bad++; $display("FAIL rand_n16 a=%h b=%h s=%b got=%h exp=%h", a, b, s, p16, e[31:0]);
          end
          e = ref_mul(32, a, b, s);
          total++;
          if ({ov32, os32, ot32, ir32, p32} !== {1'b1, s, t, 1'b1, e}) begin
            bad++; $display("FAIL rand_n32 a=%h b=%h s=%b got=%h exp=%h", a, b, s, p32, e);
          end
        end
      end
      if (i < 10700) begin
        v = (i % 16 != 15);
        s = 1'($urandom_range(0, 1));
        if (i < 50) begin
          a = corner[i % 5];
          b = corner[(i / 5) % 5];
        end else begin
          a = $urandom;
          b = $urandom;
        end
        t = TW'(i);
        drive(v, s, a, b, t);
        if (v) begin qa.push_back(a); qb.push_back(b); qs.push_back(s); qt.push_back(t); end
      end else begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
      @(negedge clk);
    end
    total++;
    if (qa.size() != 0) begin bad++; $display("FAIL rand_lost got=%0d exp=0", qa.size()); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned_max();
    test_signed_min13();
    test_mixed_n8();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r4booth_pipe.md
R4BOOTH_PIPE -- requirements
Module: r4booth_pipe

Interface
REQ-001 SHALL have parameter N, default 13, meaning operand width in bits; legal range 4..32, odd or even.
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each transaction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operands, mode and tag are presented.
REQ-006 in_ready  output  1  block accepts a transaction this cycle.
REQ-007 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 multiplicand  input  N  operand A.
REQ-009 multiplier  input  N  operand B.
REQ-010 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-011 out_valid  output  1  product, out_tag and out_signed are valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 product  output  2N  A*B.
REQ-014 out_tag  output  TAG_W  tag of the transaction in product.
REQ-015 out_signed  output  1  mode of the transaction in product.

Function
REQ-016 SHALL use radix-4 Booth recoding of B:
- B extended to E bits, E = N+1 rounded up to even.
- Sign-extension in signed mode, zero-extension in unsigned mode.
- Appended implicit 0 below bit 0.
- G = E/2 overlapping 3-bit groups.
REQ-017 SHALL map each group to a partial product in {0, +A, +2A, -A, -2A}, with A extended to 2N bits (sign- or zero-extended per mode); group i weighted by 4^i.
REQ-018 SHALL return product equal to the exact mathematical A*B represented in 2N bits (unsigned, or two's complement in signed mode) for all operand values, including the most negative value.
REQ-019 SHALL be a 3-stage pipeline:
- S1 registers the G partial products, mode, tag and valid.
- S2 registers pairwise sums of the partial products; an odd leftover passes through unchanged.
- S3 registers the final sum into product, out_signed, out_tag and out_valid.
REQ-020 SHALL accept a transaction on a rising edge where in_valid && in_ready; if not stalled, out_valid is asserted 3 edges later.
REQ-021 SHALL sustain one transaction per cycle with no bubbles while out_ready is held at 1.
REQ-022 SHALL define stall = out_valid && !out_ready; while stalled, all stage registers hold and in_ready = 0.
REQ-023 SHALL drive in_ready = !stall combinationally; in_ready has no dependency on in_valid.
REQ-024 SHALL keep product, out_tag and out_signed stable while out_valid && !out_ready.
REQ-025 SHALL let a stage holding an invalid slot advance, and shall not hold or drop valid data because of an empty downstream slot.
REQ-026 SHALL deliver results in acceptance order; no transaction lost or duplicated across any stall pattern.
REQ-027 SHALL treat a cycle where in_valid = 0 or in_ready = 0 as a bubble; operand values are ignored and no result is produced.
REQ-028 SHALL apply in_signed per transaction; mixed-mode back-to-back transactions are legal.

Reset
REQ-029 SHALL clear all valid bits and drive out_valid = 0, product = 0, out_tag = 0, out_signed = 0 immediately on rst low, independent of clk.
REQ-030 SHALL discard any in-flight transactions when reset is asserted mid-operation; no result for them appears after release.
REQ-031 SHALL drive in_ready = 1 during and after reset (no stall possible); the first acceptance is on the first rising edge after rst returns high.

Verification
REQ-032 N=13, unsigned, A = B = 8191, out_ready = 1 -> product = 67092481, out_valid exactly 3 edges after acceptance.
REQ-033 N=13, signed, A = -4096 (0x1000), B = 4095 -> product = 0x3001000; then A = B = 0x1000 -> product = 16777216 (0x1000000).
REQ-034 N=8, signed, A = B = 0x80 -> product = 0x4000; unsigned, A = B = 0xFF -> 0xFE01; issued back-to-back, in order, tags preserved.
REQ-035 Stream of 10 transactions with tags 0..9, out_ready toggled pseudo-randomly -> in_ready = 0 exactly when stalled, outputs stable during stall, results in tag order 0..9, all correct.
REQ-036 Reset pulsed asynchronously (between edges) with 2 transactions in flight -> out_valid falls at once, no stale result after release, next transaction correct.
REQ-037 Random regression for N in {4, 13, 16, 32}, both modes, >=10k vectors each -> product matches the reference model bit-exactly.
